// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Modulo-2^32 increment; FFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Single-outstanding request/response bus between the fetch stage and instruction memory.
interface imem_if;

    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] data;

    modport master (output req, output addr, input rdy, input data);
    modport slave  (input req, input addr, output rdy, output data);

endinterface

// File: rtl/fetch_skid_buf.sv
// Holds one returned instruction while ID is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the PC, fetches from variable-latency memory, drives the IF/ID register.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Stall,
    input  logic          Redirect,
    input  logic [31:0]   RedirectPC,
    imem_if.master        imem,
    output logic [31:0]   InstrID,
    output logic [31:0]   PCPlus4ID,
    output logic          ValidID,
    output logic [31:0]   PCValue
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         req;
    logic [31:0]  addr;
    logic         deliver;
    logic [31:0]  deliver_data;
    logic         skid_load, skid_clear, skid_full;
    logic [31:0]  skid_q;
    logic [31:0]  instr_p1, pc4_p1;
    logic         vld_p1;

    assign pc_plus4 = pc_next(pc_q);

    fetch_skid_buf u_skid (
        .clk   (Clk),
        .rst_n (Rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem.data),
        .dout  (skid_q),
        .full  (skid_full)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req          = 1'b0;
        addr         = pc_q;
        deliver      = 1'b0;
        deliver_data = '0;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;
        case (state_q)
            ISSUE: begin
                req = ~Redirect;
                if (Redirect) pc_d = RedirectPC;
                else          state_d = WAIT;
            end
            WAIT: begin
                if (Redirect) begin
                    pc_d    = RedirectPC;
                    // A response still in flight must be swallowed before refetching.
                    state_d = imem.rdy ? ISSUE : DRAIN;
                end else if (imem.rdy && !Stall) begin
                    deliver      = 1'b1;
                    deliver_data = imem.data;
                    pc_d         = pc_plus4;
                    req          = 1'b1;
                    addr         = pc_plus4;
                end else if (imem.rdy) begin
                    skid_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    skid_clear = 1'b1;
                    pc_d       = RedirectPC;
                    state_d    = ISSUE;
                end else if (!Stall && skid_full) begin
                    deliver      = 1'b1;
                    deliver_data = skid_q;
                    pc_d         = pc_plus4;
                    skid_clear   = 1'b1;
                    state_d      = ISSUE;
                end
            end
            DRAIN: begin
                if (Redirect) pc_d = RedirectPC;
                if (imem.rdy) state_d = ISSUE;
            end
            default: state_d = ISSUE;
        endcase
    end

    assign imem.req  = req & Rst;
    assign imem.addr = addr;

    // IF/ID register: redirect flushes, stall holds, otherwise load instruction or bubble.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (Redirect) begin
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
        end else if (!Stall) begin
            if (deliver) begin
                instr_p1 <= deliver_data;
                pc4_p1   <= pc_plus4;
                vld_p1   <= 1'b1;
            end else begin
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end
        end
    end

    assign InstrID   = instr_p1;
    assign PCPlus4ID = pc4_p1;
    assign ValidID   = vld_p1;
    assign PCValue   = pc_q;

    a_no_stray_rdy: assert property (@(posedge Clk) disable iff (!Rst)
        !(imem.rdy && (state_q == ISSUE || state_q == HOLD)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stall/redirect/latency against a reference model.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Stall, Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] instr1, pc4_1, pcv1, instr2, pc4_2, pcv2;
    logic        vld1, vld2;

    always #5 Clk = ~Clk;

    imem_if bus1 ();
    imem_if bus2 ();

    if_fetch_unit u_dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .imem(bus1), .InstrID(instr1), .PCPlus4ID(pc4_1), .ValidID(vld1), .PCValue(pcv1)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .Clk(Clk), .Rst(Rst), .Stall(1'b0), .Redirect(1'b0), .RedirectPC(32'h0),
        .imem(bus2), .InstrID(instr2), .PCPlus4ID(pc4_2), .ValidID(vld2), .PCValue(pcv2)
    );

    // One-cycle memory for the wrap instance: data = addr + 0x100.
    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            bus2.rdy  <= 1'b0;
            bus2.data <= '0;
        end else begin
            bus2.rdy  <= bus2.req;
            bus2.data <= bus2.addr + 32'h100;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: fetch pointer, outstanding request, buffered word, IF/ID contents.
    logic [31:0] m_pc, m_buf_d, m_instr, m_pc4;
    logic        m_out, m_stale, m_buf_v, m_vld;
    // Memory model for the main instance.
    logic        mem_busy, lat_rand;
    int          mem_wait, mem_lat;
    logic [31:0] mem_addr;
    logic        last_req;
    logic [31:0] last_addr;
    logic        h2_req [4];
    logic [31:0] h2_addr [4];
    int          cyc;

    task automatic model_reset();
        m_pc = 32'h0; m_out = 0; m_stale = 0; m_buf_v = 0; m_buf_d = 0;
        m_instr = NOP_INSTR_DEF; m_pc4 = 0; m_vld = 0;
        mem_busy = 0; mem_wait = 0; mem_addr = 0;
        bus1.rdy = 0; bus1.data = 0;
    endtask

    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc);
        logic        e_req, dlv, old_out;
        logic [31:0] e_addr, dv;
        Stall = st; Redirect = rd; RedirectPC = rpc;
        bus1.rdy  = mem_busy && (mem_wait == 0);
        bus1.data = bus1.rdy ? mem_addr + 32'h100 : 32'hDEAD_BEEF;
        @(negedge Clk);
        e_req = 0; e_addr = m_pc;
        if (!m_out && !m_buf_v) begin
            e_req = !rd; e_addr = m_pc;
        end else if (m_out && !m_stale && bus1.rdy && !st && !rd) begin
            e_req = 1; e_addr = m_pc + 32'd4;
        end
        check_eq("req", bus1.req, e_req);
        if (e_req) check_eq("addr", bus1.addr, e_addr);
        check_eq("valid", vld1, m_vld);
        check_eq("instr", instr1, m_instr);
        if (m_vld) check_eq("pc4", pc4_1, m_pc4);
        check_eq("pc", pcv1, m_pc);
        last_req = bus1.req; last_addr = bus1.addr;
        if (cyc < 4) begin h2_req[cyc] = bus2.req; h2_addr[cyc] = bus2.addr; end
        cyc++;
        // Next model state from the rules.
        dlv = 0; dv = 0;
        if (bus1.rdy && m_out) begin
            if (!(m_stale || rd)) begin
                if (st) begin m_buf_v = 1; m_buf_d = bus1.data; end
                else begin dlv = 1; dv = bus1.data; end
            end
        end else if (m_buf_v) begin
            if (rd) m_buf_v = 0;
            else if (!st) begin dlv = 1; dv = m_buf_d; m_buf_v = 0; end
        end
        if (rd) begin m_vld = 0; m_instr = NOP_INSTR_DEF; end
        else if (!st) begin
            if (dlv) begin m_vld = 1; m_instr = dv; m_pc4 = m_pc + 32'd4; end
            else begin m_vld = 0; m_instr = NOP_INSTR_DEF; end
        end
        if (rd) m_pc = rpc;
        else if (dlv) m_pc = m_pc + 32'd4;
        old_out = m_out;
        if (old_out && bus1.rdy) begin m_out = 0; m_stale = 0; end
        else if (old_out && rd) m_stale = 1;
        if (e_req) begin m_out = 1; m_stale = 0; end
        // Memory reacts to what the DUT actually put on the bus.
        if (bus1.rdy) mem_busy = 0;
        if (bus1.req) begin
            mem_busy = 1;
            mem_wait = (lat_rand ? int'($urandom_range(1, 4)) : mem_lat) - 1;
            mem_addr = bus1.addr;
        end else if (mem_busy && mem_wait > 0) mem_wait--;
        @(posedge Clk); #1;
    endtask

    initial begin
        Stall = 0; Redirect = 0; RedirectPC = 0;
        lat_rand = 0; mem_lat = 1; cyc = 0;
        last_req = 0; last_addr = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_valid", vld1, 32'h0);
        check_eq("rst_instr", instr1, NOP_INSTR_DEF);
        check_eq("rst_pc4", pc4_1, 32'h0);
        check_eq("rst_req", bus1.req, 32'h0);
        check_eq("rst_pc", pcv1, 32'h0);
        Rst = 1;

        // Back-to-back fetch with 1-cycle memory.
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_eq("wrap_instr", instr2, 32'h0000_00FC);
        check_eq("wrap_pc4", pc4_2, 32'h0);
        check_eq("wrap_valid", vld2, 32'h1);
        check_eq("wrap_pc", pcv2, 32'h0);
        check_eq("wrap_req0", h2_req[0], 32'h1);
        check_eq("wrap_addr0", h2_addr[0], 32'hFFFF_FFFC);
        check_eq("wrap_addr1", h2_addr[1], 32'h0);
        cycle(0, 0, 0);
        check_eq("seq_instr", instr1, 32'h104);
        check_eq("seq_pc4", pc4_1, 32'h8);

        // Stall for three cycles while the 0x8 response lands.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            check_eq("stall_req", last_req, 32'h0);
            check_eq("stall_hold", instr1, 32'h104);
        end
        cycle(0, 0, 0);
        check_eq("rel_instr", instr1, 32'h108);
        check_eq("rel_pc4", pc4_1, 32'hC);
        mem_lat = 3;
        cycle(0, 0, 0);
        check_eq("rel_fetch", last_addr, 32'hC);

        // Redirect while waiting; the late response is dropped.
        cycle(0, 1, 32'h40);
        check_eq("redir_bubble", vld1, 32'h0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check_eq("drain_bubble", vld1, 32'h0);
        mem_lat = 1;
        cycle(0, 0, 0);
        check_eq("redir_req", last_req, 32'h1);
        check_eq("redir_addr", last_addr, 32'h40);
        cycle(0, 0, 0);
        check_eq("redir_instr", instr1, 32'h140);
        check_eq("redir_valid", vld1, 32'h1);

        // Stall and redirect together while holding.
        cycle(1, 0, 0);
        cycle(1, 1, 32'h80);
        check_eq("hold_redir_valid", vld1, 32'h0);
        check_eq("hold_redir_pc", pcv1, 32'h80);
        mem_lat = 3;
        cycle(0, 0, 0);
        check_eq("hold_redir_addr", last_addr, 32'h80);

        // Asynchronous reset in the middle of a wait.
        cycle(0, 0, 0);
        #2 Rst = 0;
        #1;
        check_eq("arst_valid", vld1, 32'h0);
        check_eq("arst_instr", instr1, NOP_INSTR_DEF);
        check_eq("arst_req", bus1.req, 32'h0);
        check_eq("arst_pc", pcv1, 32'h0);
        check_eq("arst_wrap_pc", pcv2, 32'hFFFF_FFFC);
        model_reset();
        @(posedge Clk); #1;
        Rst = 1;
        mem_lat = 1;
        cycle(0, 0, 0);
        check_eq("arst_first_req", last_req, 32'h1);
        check_eq("arst_first_addr", last_addr, 32'h0);

        // Random stall / redirect / latency.
        lat_rand = 1;
        for (int i = 0; i < 600; i++) begin
            logic        st, rd;
            logic [31:0] rpc;
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cycle(st, rd, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
